// File: rtl/als_spi_master.sv
// SPI master for the PmodALS (ADC081S021) light sensor: frames cs/scl, shifts in 16 bits, presents an 8-bit sample.
// Optional macro ALS_AVG_EN replaces the raw sample with a 4-frame moving average.
module als_spi_master #(
    parameter int CLK_DIV   = 25,
    parameter int FRAME_GAP = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sdo,
    output logic       cs,
    output logic       scl,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      shreg;
    logic             div_end;
    logic             gap_end;
    logic             frame_end;
    logic [7:0]       raw;
    logic [7:0]       sample_next;

    assign div_end   = (div_cnt == DIV_LAST);
    assign gap_end   = (gap_cnt == GAP_LAST);
    assign raw       = shreg[12:5];
    // Last high phase of the 16th bit: the word in shreg is complete.
    assign frame_end = (state == SHIFT) && scl && div_end && (bit_cnt == 4'd15);

`ifdef ALS_AVG_EN
    logic [7:0] hist [4];
    logic [9:0] sum;
    logic [9:0] sum_next;

    always_comb begin
        sum_next    = sum + {2'b00, raw} - {2'b00, hist[3]};
        sample_next = sum_next[9:2];
    end

    // The running sum always equals the total of the four history entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
            hist[3] <= '0;
            sum     <= '0;
        end else if (frame_end) begin
            hist[0] <= raw;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            sum     <= sum_next;
        end
    end
`else
    assign sample_next = raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            cs           <= 1'b1;
            scl          <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cs      <= 1'b1;
                    scl     <= 1'b1;
                    busy    <= 1'b0;
                    div_cnt <= '0;
                    if (en) begin
                        state <= SETUP;
                        cs    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        scl     <= 1'b0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // The scl register itself records which half of the bit we are in.
                    if (div_end) begin
                        div_cnt <= '0;
                        if (!scl) begin
                            scl   <= 1'b1;
                            shreg <= {shreg[14:0], sdo};
                        end else if (bit_cnt == 4'd15) begin
                            state        <= DONE;
                            cs           <= 1'b1;
                            sample       <= sample_next;
                            frame_err    <= |shreg[15:13];
                            sample_valid <= 1'b1;
                            bit_cnt      <= '0;
                        end else begin
                            scl     <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_end) begin
                        gap_cnt <= '0;
                        if (en) begin
                            state <= SETUP;
                            cs    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cs    <= 1'b1;
                    scl   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_als_spi_master.sv
// Directed self-checking bench for als_spi_master with a behavioural ADC081S021 sensor model.
// Define ALS_AVG_EN for both files to exercise the moving-average build.
`timescale 1ns/1ps
module tb_als_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       sdo = 1'b0;
    logic       cs;
    logic       scl;
    logic [7:0] sample;
    logic       sample_valid;
    logic       frame_err;
    logic       busy;

    logic [15:0] word = 16'h0000;
    int          nbit = 0;
    int          checks = 0;
    int          errors = 0;
    int          sv_count = 0;

    als_spi_master #(.CLK_DIV(2), .FRAME_GAP(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sdo(sdo),
        .cs(cs),
        .scl(scl),
        .sample(sample),
        .sample_valid(sample_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sample_valid) sv_count++;

    // Sensor presents the MSB at cs fall and the next bit on every scl fall.
    always @(negedge cs or negedge scl) begin
        if (!cs) begin
            if (scl) begin
                nbit = 0;
                sdo  = word[15];
            end else begin
                sdo = word[15 - nbit];
                if (nbit < 15) nbit++;
            end
        end
    end

`ifdef ALS_AVG_EN
    logic [7:0] mh [4] = '{default: 8'h00};
`endif

    task automatic model_reset();
`ifdef ALS_AVG_EN
        for (int i = 0; i < 4; i++) mh[i] = 8'h00;
`endif
    endtask

    task automatic model_sample(input logic [7:0] raw, output logic [7:0] exp_s);
`ifdef ALS_AVG_EN
        int total;
        mh[3] = mh[2];
        mh[2] = mh[1];
        mh[1] = mh[0];
        mh[0] = raw;
        total = int'(mh[0]) + int'(mh[1]) + int'(mh[2]) + int'(mh[3]);
        exp_s = 8'(total / 4);
`else
        exp_s = raw;
`endif
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget, output longint t);
        bit found = 0;
        t = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                found = 1;
                t = $time;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout observed=no sample_valid expected=pulse within %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_cs_low(input string tag, input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!cs) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout observed=cs high expected=cs fall within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        longint t1, t2, tx;
        logic [7:0] exp_s;
        int sv_snap;

        rst_n = 1'b1;
        en    = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with en low: nothing may start.
        repeat (100) @(negedge clk);
        check("idle_cs", cs, 1);
        check("idle_scl", scl, 1);
        check("idle_busy", busy, 0);
        check("idle_sample", sample, 8'h00);
        check("idle_err", frame_err, 0);
        check("idle_no_valid", sv_count, 0);

        // Continuous frames of 0x0AA0.
        word = 16'h0AA0;
        en   = 1'b1;
        wait_valid("frame1", 200, t1);
        model_sample(8'h55, exp_s);
        check("frame1_sample", sample, exp_s);
        check("frame1_err", frame_err, 0);
        check("frame1_cs_high", cs, 1);
        @(negedge clk);
        check("valid_one_cycle", sample_valid, 0);
        wait_valid("frame2", 200, t2);
        model_sample(8'h55, exp_s);
        check("frame2_sample", sample, exp_s);
        check("frame_period", 32'(t2 - t1), 32'd710);

        // Nonzero leading bit flags an error but still yields the data.
        word = 16'h2AA0;
        wait_valid("frame3", 200, tx);
        model_sample(8'h55, exp_s);
        check("err_frame_sample", sample, exp_s);
        check("err_frame_err", frame_err, 1);
        word = 16'h0FE0;
        wait_valid("frame4", 200, tx);
        model_sample(8'h7F, exp_s);
        check("frame4_sample", sample, exp_s);
        check("frame4_err", frame_err, 0);

        // Drop en during bit 8: frame must complete, then GAP, then IDLE.
        word = 16'h0AA0;
        wait_cs_low("stop_cs_fall", 50);
        repeat (34) @(negedge clk);
        check("bit8_cs_low", cs, 0);
        en = 1'b0;
        wait_valid("stop_frame", 200, tx);
        model_sample(8'h55, exp_s);
        check("stop_frame_sample", sample, exp_s);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("gap_busy", busy, 1);
            check("gap_cs", cs, 1);
        end
        @(negedge clk);
        check("stop_idle_busy", busy, 0);
        sv_snap = sv_count;
        repeat (20) @(negedge clk);
        check("stop_stays_idle_cs", cs, 1);
        check("stop_no_more_valid", sv_count, sv_snap);

        // Asynchronous reset in the low phase of bit 10.
        word = 16'h0FE0;
        en   = 1'b1;
        wait_cs_low("rst_cs_fall", 50);
        repeat (42) @(negedge clk);
        check("bit10_scl_low", scl, 0);
        sv_snap = sv_count;
        #1 rst_n = 1'b0;
        #1;
        check("rst_cs_async", cs, 1);
        check("rst_scl_async", scl, 1);
        check("rst_sample", sample, 8'h00);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        model_reset();
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_no_valid", sv_count, sv_snap);
        check("rst_idle_cs", cs, 1);

`ifdef ALS_AVG_EN
        // Moving average from a zeroed history.
        word = 16'h0200;
        en   = 1'b1;
        wait_valid("avg1", 200, tx);
        check("avg1_sample", sample, 8'h04);
        word = 16'h0400;
        wait_valid("avg2", 200, tx);
        check("avg2_sample", sample, 8'h0C);
        word = 16'h0600;
        wait_valid("avg3", 200, tx);
        check("avg3_sample", sample, 8'h18);
        word = 16'h0800;
        wait_valid("avg4", 200, tx);
        check("avg4_sample", sample, 8'h28);
        en = 1'b0;
        repeat (10) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout observed=still running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule

// File: doc/als_spi_master.md
# als_spi_master

Upstream SPI master for the PmodALS light-sensor path (ADC081S021). Runs from the system clock, generates `cs` and `scl` for the sensor, and shifts in the 16-bit frame on `sdo`. Checks the frame's leading zeros and presents the 8-bit light sample with a one-cycle valid pulse. Its `cs`/`scl`/`sdo` nets are the same ones the downstream `controller_PmodALS` capture logic observes.

## Interface
- `CLK_DIV`, 25: system-clock cycles per `scl` half-period; legal range ≥1.
- `FRAME_GAP`, 50: system-clock cycles `cs` stays high between frames; legal range ≥1.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous assertion, active-low.
- `en` in 1: continuous-conversion enable.
- `sdo` in 1: sensor serial data, MSB first.
- `cs` out 1: sensor chip select, active-low.
- `scl` out 1: SPI clock, idles high.
- `sample` out 8: last light value; holds between frames.
- `sample_valid` out 1: one-cycle pulse when `sample` and `frame_err` update.
- `frame_err` out 1: last frame had a nonzero leading bit; holds between frames.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values: `cs`=1, `scl`=1, `sample`=0, `sample_valid`=0, `frame_err`=0, `busy`=0. State is IDLE; all counters and the shift register are 0.
- States and transitions:
  - IDLE: `cs`=1, `scl`=1. Moves to SETUP when `en`=1.
  - SETUP: `cs`=0, `scl`=1 for CLK_DIV cycles, then moves to SHIFT.
  - SHIFT: 16 bits, each with a low phase then a high phase.
    - Low phase: `scl`=0 for CLK_DIV cycles.
    - High phase: `scl`=1 for CLK_DIV cycles.
    - `sdo` is shifted into `shreg[0]` (shift left) on the clk edge that drives `scl` 0→1.
    - A 4-bit bit counter ends SHIFT after the 16th high phase and moves to DONE.
  - DONE, 1 cycle:
    - `cs`=1.
    - `sample` ← `shreg[12:5]`.
    - `frame_err` ← (`shreg[15:13]` != 0).
    - `sample_valid`=1.
    - `shreg[4:0]` is ignored.
    - Moves to GAP.
  - GAP: `cs`=1, `scl`=1 for FRAME_GAP cycles. Then moves to SETUP if `en`=1, else to IDLE.
- `en` is examined only in IDLE and at the end of GAP. Deasserting `en` mid-frame never truncates a frame: the frame completes, DONE and GAP run, then the block enters IDLE.
- Asserting `rst_n`=0 mid-frame forces `cs`=1 and `scl`=1 immediately, without waiting for a clock edge. The partial frame is discarded and no `sample_valid` is produced.
- The counters are sized by `$clog2` of their parameter. The half-period counter counts 0..CLK_DIV-1 and wraps.

## Timing
- Frame period with `en` held high is CLK_DIV + 32·CLK_DIV + 1 + FRAME_GAP cycles. For the defaults that is 25 + 800 + 1 + 50 = 876 cycles.
- The first `cs` fall occurs on the clk edge after `en` is seen high in IDLE.
- `sample_valid` rises on the same edge as `cs` rises. It is high for exactly 1 cycle.
- The `scl` duty cycle is exactly 50% in SHIFT. `scl` is glitch-free: it is driven directly from a register.
- Minimum `cs`-high time is FRAME_GAP + 1 cycles, counting DONE.

## Configuration
- `ALS_AVG_EN` defined:
  - `sample` is the 4-frame moving average ⌊(s0+s1+s2+s3)/4⌋, using a 10-bit sum and a 4-entry history of raw `shreg[12:5]`.
  - The history is zero-filled at reset, so averaging starts from zeros.
  - Error frames are still pushed into the history.
  - `sample_valid` timing is unchanged.
- `ALS_AVG_EN` undefined: `sample` is the raw `shreg[12:5]` and no history registers exist.

## Test plan
All scenarios use CLK_DIV=2, FRAME_GAP=4 and a behavioural sensor that shifts its word out on `scl` falling edges, starting at the `cs` fall.

- Reset, `en`=0 for 100 cycles → `cs`=1, `scl`=1, `busy`=0, `sample`=0x00, no `sample_valid`.
- `en`=1, sensor word 0x0AA0 → `sample`=0x55, `frame_err`=0. `sample_valid` pulses once per frame, and consecutive pulses are exactly 71 cycles apart.
- Sensor word 0x2AA0 → `sample`=0x55, `frame_err`=1. A following frame of 0x0FE0 → `sample`=0x7F, `frame_err`=0.
- Drop `en` during bit 8 of a frame → the frame completes, `sample_valid` pulses, `cs` stays high, and `busy`=0 after 4 GAP cycles.
- Pulse `rst_n` low at bit 10 → `cs`=1 and `scl`=1 during reset with no clock edge required, `sample` and `frame_err` read 0, and no `sample_valid` occurs.
- With `ALS_AVG_EN`, frames carrying data 0x10, 0x20, 0x30, 0x40 → successive `sample` values 0x04, 0x0C, 0x18, 0x28.
